// File: rtl/pwm32_core.sv
// Timer/PWM engine: prescaled up-counter with shadowed period/duty compares.
// Register writes take effect only at start or at a period wrap.
module pwm32_core (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PRE,
    input  logic [31:0] TMRCMP1,
    input  logic [31:0] TMRCMP2,
    input  logic        TMREN,
    output logic        PWM,
    output logic [31:0] TMR,
    output logic        PERIOD_DONE
);

    logic [31:0] r_pre_cnt, r_tmr, r_sh_pre, r_sh_cmp1, r_sh_cmp2;
    logic        r_en, r_pwm, r_done;

    logic [31:0] w_pre_cnt_d, w_tmr_d, w_sh_pre_d, w_sh_cmp1_d, w_sh_cmp2_d;
    logic        w_en_d, w_pwm_d, w_done_d;
    logic        w_tick, w_wrap;

    assign w_tick = (r_pre_cnt == r_sh_pre);
    assign w_wrap = w_tick && (r_tmr == r_sh_cmp1);

    always_comb begin
        w_en_d      = r_en;
        w_pre_cnt_d = r_pre_cnt;
        w_tmr_d     = r_tmr;
        w_sh_pre_d  = r_sh_pre;
        w_sh_cmp1_d = r_sh_cmp1;
        w_sh_cmp2_d = r_sh_cmp2;
        w_done_d    = 1'b0;
        if (!TMREN) begin
            w_en_d      = 1'b0;
            w_pre_cnt_d = '0;
            w_tmr_d     = '0;
        end else if (!r_en) begin
            w_en_d      = 1'b1;
            w_pre_cnt_d = '0;
            w_tmr_d     = '0;
            w_sh_pre_d  = PRE;
            w_sh_cmp1_d = TMRCMP1;
            w_sh_cmp2_d = TMRCMP2;
        end else if (w_tick) begin
            w_pre_cnt_d = '0;
            if (w_wrap) begin
                w_tmr_d     = '0;
                w_done_d    = 1'b1;
                w_sh_pre_d  = PRE;
                w_sh_cmp1_d = TMRCMP1;
                w_sh_cmp2_d = TMRCMP2;
            end else begin
                w_tmr_d = r_tmr + 32'd1;
            end
        end else begin
            w_pre_cnt_d = r_pre_cnt + 32'd1;
        end
    end

    // PWM is computed from the pre-edge state, so it lags the count by one clock.
    assign w_pwm_d = r_en & (r_tmr < r_sh_cmp2);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en      <= 1'b0;
            r_pre_cnt <= '0;
            r_tmr     <= '0;
            r_sh_pre  <= '0;
            r_sh_cmp1 <= '0;
            r_sh_cmp2 <= '0;
            r_pwm     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_en      <= w_en_d;
            r_pre_cnt <= w_pre_cnt_d;
            r_tmr     <= w_tmr_d;
            r_sh_pre  <= w_sh_pre_d;
            r_sh_cmp1 <= w_sh_cmp1_d;
            r_sh_cmp2 <= w_sh_cmp2_d;
            r_pwm     <= w_pwm_d;
            r_done    <= w_done_d;
        end
    end

    assign PWM         = r_pwm;
    assign TMR         = r_tmr;
    assign PERIOD_DONE = r_done;

endmodule

// File: tb/tb_pwm32_core.sv
// Directed bench for pwm32_core: per-clock vector table plus hand-written
// sequences for mid-period register writes, restart and asynchronous reset.
module tb_pwm32_core;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b1;
    logic [31:0] PRE = '0, TMRCMP1 = '0, TMRCMP2 = '0;
    logic        TMREN = 1'b0;
    logic        PWM, PERIOD_DONE;
    logic [31:0] TMR;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pre;
        logic [31:0] c1;
        logic [31:0] c2;
        logic        en;
        logic        pwm;
        logic [31:0] tmr;
        logic        done;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    pwm32_core dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PRE         (PRE),
        .TMRCMP1     (TMRCMP1),
        .TMRCMP2     (TMRCMP2),
        .TMREN       (TMREN),
        .PWM         (PWM),
        .TMR         (TMR),
        .PERIOD_DONE (PERIOD_DONE)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic [31:0] pre, input logic [31:0] c1,
                                input logic [31:0] c2, input logic en, input logic pwm,
                                input logic [31:0] tmr, input logic done, input string nm);
        vec_t v;
        v.pre = pre; v.c1 = c1; v.c2 = c2; v.en = en;
        v.pwm = pwm; v.tmr = tmr; v.done = done; v.nm = nm;
        vecs.push_back(v);
    endfunction

    // Drive inputs on the falling edge, check one time unit after the rising edge.
    task automatic cyc(input logic [31:0] pre, input logic [31:0] c1, input logic [31:0] c2,
                       input logic en, input logic pwm, input logic [31:0] tmr,
                       input logic done, input string nm);
        @(negedge PCLK);
        PRE = pre; TMRCMP1 = c1; TMRCMP2 = c2; TMREN = en;
        @(posedge PCLK);
        #1;
        chk({nm, ".pwm"}, {31'd0, PWM}, {31'd0, pwm});
        chk({nm, ".tmr"}, TMR, tmr);
        chk({nm, ".done"}, {31'd0, PERIOD_DONE}, {31'd0, done});
    endtask

    initial begin
        // idle after reset
        add(0, 3, 2, 0, 0, 0, 0, "idle");
        // PRE=0 CMP1=3 CMP2=2: period 4, PWM 1,1,0,0
        add(0, 3, 2, 1, 0, 0, 0, "a_start");
        add(0, 3, 2, 1, 1, 1, 0, "a1");
        add(0, 3, 2, 1, 1, 2, 0, "a2");
        add(0, 3, 2, 1, 0, 3, 0, "a3");
        add(0, 3, 2, 1, 0, 0, 1, "a_wrap1");
        add(0, 3, 2, 1, 1, 1, 0, "a5");
        add(0, 3, 2, 1, 1, 2, 0, "a6");
        add(0, 3, 2, 1, 0, 3, 0, "a7");
        add(0, 3, 2, 1, 0, 0, 1, "a_wrap2");
        add(0, 3, 2, 0, 1, 0, 0, "a_stop1");
        add(0, 3, 2, 0, 0, 0, 0, "a_stop2");
        // PRE=1 CMP1=4 CMP2=1: period 10, 2 high, each count held 2 clocks
        add(1, 4, 1, 1, 0, 0, 0, "b_start");
        add(1, 4, 1, 1, 1, 0, 0, "b1");
        add(1, 4, 1, 1, 1, 1, 0, "b2");
        add(1, 4, 1, 1, 0, 1, 0, "b3");
        add(1, 4, 1, 1, 0, 2, 0, "b4");
        add(1, 4, 1, 1, 0, 2, 0, "b5");
        add(1, 4, 1, 1, 0, 3, 0, "b6");
        add(1, 4, 1, 1, 0, 3, 0, "b7");
        add(1, 4, 1, 1, 0, 4, 0, "b8");
        add(1, 4, 1, 1, 0, 4, 0, "b9");
        add(1, 4, 1, 1, 0, 0, 1, "b_wrap");
        add(1, 4, 1, 1, 1, 0, 0, "b11");
        add(1, 4, 1, 1, 1, 1, 0, "b12");
        add(1, 4, 1, 1, 0, 1, 0, "b13");
        add(1, 4, 1, 0, 0, 0, 0, "b_stop1");
        add(1, 4, 1, 0, 0, 0, 0, "b_stop2");
        // CMP2=0: never high
        add(0, 3, 0, 1, 0, 0, 0, "c_start");
        add(0, 3, 0, 1, 0, 1, 0, "c1");
        add(0, 3, 0, 1, 0, 2, 0, "c2");
        add(0, 3, 0, 1, 0, 3, 0, "c3");
        add(0, 3, 0, 1, 0, 0, 1, "c_wrap");
        add(0, 3, 0, 1, 0, 1, 0, "c5");
        add(0, 3, 0, 0, 0, 0, 0, "c_stop");
        // CMP2>CMP1: always high while enabled, wrap still pulses
        add(0, 3, 5, 1, 0, 0, 0, "d_start");
        add(0, 3, 5, 1, 1, 1, 0, "d1");
        add(0, 3, 5, 1, 1, 2, 0, "d2");
        add(0, 3, 5, 1, 1, 3, 0, "d3");
        add(0, 3, 5, 1, 1, 0, 1, "d_wrap1");
        add(0, 3, 5, 1, 1, 1, 0, "d5");
        add(0, 3, 5, 1, 1, 2, 0, "d6");
        add(0, 3, 5, 1, 1, 3, 0, "d7");
        add(0, 3, 5, 1, 1, 0, 1, "d_wrap2");
        add(0, 3, 5, 0, 1, 0, 0, "d_stop1");
        add(0, 3, 5, 0, 0, 0, 0, "d_stop2");

        // asynchronous reset before any clock edge
        #2 PRESETn = 1'b0;
        #1;
        chk("rst.pwm", {31'd0, PWM}, 32'd0);
        chk("rst.tmr", TMR, 32'd0);
        chk("rst.done", {31'd0, PERIOD_DONE}, 32'd0);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;

        foreach (vecs[i])
            cyc(vecs[i].pre, vecs[i].c1, vecs[i].c2, vecs[i].en,
                vecs[i].pwm, vecs[i].tmr, vecs[i].done, vecs[i].nm);

        // Mid-period duty write: CMP2 2->6 once TMR=3, effective after the wrap
        cyc(0, 7, 2, 1, 0, 0, 0, "e_start");
        cyc(0, 7, 2, 1, 1, 1, 0, "e1");
        cyc(0, 7, 2, 1, 1, 2, 0, "e2");
        cyc(0, 7, 2, 1, 0, 3, 0, "e3");
        for (int i = 4; i < 8; i++) cyc(0, 7, 6, 1, 0, i, 0, "e_old_duty");
        cyc(0, 7, 6, 1, 0, 0, 1, "e_wrap1");
        for (int i = 1; i < 7; i++) cyc(0, 7, 6, 1, 1, i, 0, "e_new_duty");
        cyc(0, 7, 6, 1, 0, 7, 0, "e15");
        cyc(0, 7, 6, 1, 0, 0, 1, "e_wrap2");
        for (int i = 1; i < 6; i++) cyc(0, 7, 6, 1, 1, i, 0, "e_run");
        // drop enable at TMR=5 for one clock, then restart with new registers
        cyc(0, 7, 6, 0, 1, 0, 0, "e_stop");
        cyc(0, 3, 1, 1, 0, 0, 0, "e_restart");
        cyc(0, 3, 1, 1, 1, 1, 0, "e_restart1");

        // asynchronous reset mid-period while PWM is high
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst.pwm", {31'd0, PWM}, 32'd0);
        chk("midrst.tmr", TMR, 32'd0);
        chk("midrst.done", {31'd0, PERIOD_DONE}, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        chk("post_rst.tmr", TMR, 32'd0);
        chk("post_rst.pwm", {31'd0, PWM}, 32'd0);
        cyc(0, 3, 1, 1, 1, 1, 0, "post_rst1");
        cyc(0, 3, 1, 1, 0, 2, 0, "post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
